// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI4-Lite response codes and cfg sequencer state encoding
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WR    = 3'd2,
        ST_WRESP = 3'd3,
        ST_RADDR = 3'd4,
        ST_RDATA = 3'd5,
        ST_NEXT  = 3'd6
    } seq_state_t;

    function automatic logic resp_ok(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_wr_issue.sv
// rtl/axi_lite_wr_issue.sv - AW/W dual-valid issue plus B wait, reporting a registered done/resp pair
module axi_lite_wr_issue
    import axi_lite_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       issue,
    output logic       awvalid,
    input  logic       awready,
    output logic       wvalid,
    input  logic       wready,
    input  logic [1:0] bresp,
    input  logic       bvalid,
    output logic       bready,
    output logic       addr_done,
    output logic       done,
    output logic [1:0] resp
);

    logic aw_pend;
    logic w_pend;
    logic b_wait;
    logic aw_fin;
    logic w_fin;

    assign awvalid = aw_pend;
    assign wvalid  = w_pend;
    assign bready  = b_wait;

    // A channel counts as finished if it already handshook or handshakes this cycle
    assign aw_fin    = !aw_pend || awready;
    assign w_fin     = !w_pend  || wready;
    assign addr_done = (aw_pend || w_pend) && aw_fin && w_fin;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            b_wait  <= 1'b0;
            done    <= 1'b0;
            resp    <= RESP_OKAY;
        end else begin
            done <= 1'b0;
            if (issue) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end else begin
                if (aw_pend && awready) begin
                    aw_pend <= 1'b0;
                end
                if (w_pend && wready) begin
                    w_pend <= 1'b0;
                end
                if (addr_done) begin
                    b_wait <= 1'b1;
                end
                if (b_wait && bvalid) begin
                    b_wait <= 1'b0;
                    done   <= 1'b1;
                    resp   <= bresp;
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_cfg_sequencer.sv
// rtl/axi_lite_cfg_sequencer.sv - AXI4-Lite master writing an (addr, data) table with optional readback verify
module axi_lite_cfg_sequencer
    import axi_lite_pkg::*;
#(
    parameter int P_M_AXI_DATA_WIDTH = 32,
    parameter int P_M_AXI_ADDR_WIDTH = 4,
    parameter int P_TBL_DEPTH        = 4,
    parameter int P_TBL_IDX_WIDTH    = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            i_start,
    input  logic                            i_verify_en,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    output logic [P_TBL_IDX_WIDTH-1:0]      o_tbl_idx,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0]   i_tbl_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]   i_tbl_data,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [P_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [P_TBL_IDX_WIDTH-1:0] IDX_LAST = P_TBL_IDX_WIDTH'(P_TBL_DEPTH - 1);
    localparam logic [P_TBL_IDX_WIDTH-1:0] IDX_ONE  = P_TBL_IDX_WIDTH'(1);

    seq_state_t                    state;
    seq_state_t                    state_nxt;
    logic                          verify_q;
    logic [P_M_AXI_DATA_WIDTH-1:0] cmp_q;
    logic                          wr_issue;
    logic                          wr_addr_done;
    logic                          wr_done;
    logic [1:0]                    wr_resp;
    logic                          ok_exit;
    logic                          err_exit;
    logic                          last_entry;

    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_ARVALID = (state == ST_RADDR);
    assign M_AXI_RREADY  = (state == ST_RDATA);
    assign last_entry    = (o_tbl_idx == IDX_LAST);

    axi_lite_wr_issue wr_issue_inst (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .issue     (wr_issue),
        .awvalid   (M_AXI_AWVALID),
        .awready   (M_AXI_AWREADY),
        .wvalid    (M_AXI_WVALID),
        .wready    (M_AXI_WREADY),
        .bresp     (M_AXI_BRESP),
        .bvalid    (M_AXI_BVALID),
        .bready    (M_AXI_BREADY),
        .addr_done (wr_addr_done),
        .done      (wr_done),
        .resp      (wr_resp)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_issue  = 1'b0;
        ok_exit   = 1'b0;
        err_exit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wr_issue  = 1'b1;
                state_nxt = ST_WR;
            end
            ST_WR: begin
                if (wr_addr_done) begin
                    state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (wr_done) begin
                    if (!resp_ok(wr_resp)) begin
                        err_exit  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (verify_q) begin
                        state_nxt = ST_RADDR;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
            end
            ST_RADDR: begin
                if (M_AXI_ARREADY) begin
                    state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (M_AXI_RVALID) begin
                    if (!resp_ok(M_AXI_RRESP) || (M_AXI_RDATA != cmp_q)) begin
                        err_exit  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (last_entry) begin
                    ok_exit   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status and payload registers; the index freezes on an error exit so it names the failing entry
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_tbl_idx    <= '0;
            verify_q     <= 1'b0;
            cmp_q        <= '0;
            M_AXI_AWADDR <= '0;
            M_AXI_ARADDR <= '0;
            M_AXI_WDATA  <= '0;
        end else begin
            o_done <= ok_exit || err_exit;
            if (state == ST_IDLE && i_start) begin
                o_busy    <= 1'b1;
                o_err     <= 1'b0;
                o_tbl_idx <= '0;
                verify_q  <= i_verify_en;
            end
            if (state == ST_LOAD) begin
                M_AXI_AWADDR <= i_tbl_addr;
                M_AXI_ARADDR <= i_tbl_addr;
                M_AXI_WDATA  <= i_tbl_data;
                cmp_q        <= i_tbl_data;
            end
            if (state == ST_NEXT && !last_entry) begin
                o_tbl_idx <= o_tbl_idx + IDX_ONE;
            end
            if (err_exit) begin
                o_err <= 1'b1;
            end
            if (ok_exit || err_exit) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule
